// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: follows destination-register writes through EX/MEM/WB,
// raises the load-use stall that forwarding cannot cover, and exports a per-register busy map.
module hazard_scoreboard #(
  parameter int NREG   = 8,
  parameter int PERF_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_Rdst,
  input  logic                    issue_WB,
  input  logic                    issue_is_load,
  input  logic [$clog2(NREG)-1:0] Rsrc1,
  input  logic [$clog2(NREG)-1:0] Rsrc2,
  input  logic                    use_src1,
  input  logic                    use_src2,
  input  logic                    hold,
  input  logic                    flush,
  output logic                    stall,
  output logic [NREG-1:0]         busy,
  output logic [PERF_W-1:0]       stall_count
);

  localparam int RW = $clog2(NREG);

  // Handshake: decode offers an instruction with issue_valid; it is taken on an edge where
  // accept is high. While stall, hold or flush is high decode keeps re-presenting it.

  typedef struct packed {
    logic          v;
    logic          wb;
    logic [RW-1:0] rdst;
    logic          ld;
  } tag_t;

  // The load flag only matters while the load sits in EX; MEM and WB carry the write part.
  typedef struct packed {
    logic          v;
    logic          wb;
    logic [RW-1:0] rdst;
  } wtag_t;

  tag_t  ex_q;
  wtag_t mem_q;
  wtag_t wb_q;
  tag_t  issue_tag;

  logic [1:0]      cnt_q [NREG];
  logic [1:0]      cnt_d [NREG];
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec_wb;
  logic [NREG-1:0] dec_fl;
  logic [NREG-1:0] ovf;
  logic [NREG-1:0] unf;
  logic [NREG-1:0] busy_d;
  logic [2:0]      up;
  logic [2:0]      dn;
  logic [2:0]      diff;

  logic src_hit;
  logic accept;
  logic retire;
  logic count_stall;

  assign src_hit = (use_src1 & (Rsrc1 == ex_q.rdst)) |
                   (use_src2 & (Rsrc2 == ex_q.rdst));

  assign stall  = rst & ex_q.v & ex_q.wb & ex_q.ld & issue_valid & src_hit;
  assign accept = issue_valid & ~stall & ~hold & ~flush;

  // A flush replaces WB with old MEM, so the WB entry leaves even if hold is also high.
  assign retire      = wb_q.v & wb_q.wb & (flush | ~hold);
  assign count_stall = stall & ~hold & ~flush & ~(&stall_count);

  always_comb begin
    issue_tag      = '0;
    issue_tag.v    = 1'b1;
    issue_tag.wb   = issue_WB;
    issue_tag.rdst = issue_Rdst;
    issue_tag.ld   = issue_is_load;
  end

  always_comb begin
    inc    = '0;
    dec_wb = '0;
    dec_fl = '0;
    ovf    = '0;
    unf    = '0;
    busy_d = '0;
    up     = '0;
    dn     = '0;
    diff   = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r]  = cnt_q[r];
      inc[r]    = accept & issue_WB & (issue_Rdst == RW'(r));
      dec_wb[r] = retire & (wb_q.rdst == RW'(r));
      dec_fl[r] = flush & ex_q.v & ex_q.wb & (ex_q.rdst == RW'(r));
      up        = {1'b0, cnt_q[r]} + {2'b00, inc[r]};
      dn        = {2'b00, dec_wb[r]} + {2'b00, dec_fl[r]};
      diff      = up - dn;
      unf[r]    = (up < dn);
      ovf[r]    = ~unf[r] & (diff > 3'd3);
      cnt_d[r]  = diff[1:0];
      busy_d[r] = (diff[1:0] != 2'd0);
    end
  end

  // Tag pipeline: flush outranks hold, hold outranks normal advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (flush) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= mem_q;
    end else if (!hold) begin
      ex_q       <= accept ? issue_tag : '0;
      mem_q.v    <= ex_q.v;
      mem_q.wb   <= ex_q.wb;
      mem_q.rdst <= ex_q.rdst;
      wb_q       <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= 2'd0;
      end
      busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (count_stall) begin
      stall_count <= stall_count + PERF_W'(1);
    end
  end

  // At most three writes can be in flight, so a counter leaving 0..3 is a tracking bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) ovf == '0);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) unf == '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver pushes hand-computed {stall, busy, stall_count}
// per cycle into a queue, and a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int NREG   = 8;
  localparam int PERF_W = 8;
  localparam int W      = 1 + NREG + PERF_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [2:0]        issue_Rdst;
  logic              issue_WB;
  logic              issue_is_load;
  logic [2:0]        Rsrc1;
  logic [2:0]        Rsrc2;
  logic              use_src1;
  logic              use_src2;
  logic              hold;
  logic              flush;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic [PERF_W-1:0] stall_count;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] act_w;
  string        nm_s;
  int           total = 0;
  int           bad   = 0;

  hazard_scoreboard #(.NREG(NREG), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_Rdst   (issue_Rdst),
    .issue_WB     (issue_WB),
    .issue_is_load(issue_is_load),
    .Rsrc1        (Rsrc1),
    .Rsrc2        (Rsrc2),
    .use_src1     (use_src1),
    .use_src2     (use_src2),
    .hold         (hold),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .stall_count  (stall_count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic nop();
    issue_valid   = 1'b0;
    issue_Rdst    = 3'd0;
    issue_WB      = 1'b0;
    issue_is_load = 1'b0;
    Rsrc1         = 3'd0;
    Rsrc2         = 3'd0;
    use_src1      = 1'b0;
    use_src2      = 1'b0;
    hold          = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic wb, input logic ld,
                       input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2);
    issue_valid   = 1'b1;
    issue_Rdst    = rd;
    issue_WB      = wb;
    issue_is_load = ld;
    Rsrc1         = s1;
    use_src1      = u1;
    Rsrc2         = s2;
    use_src2      = u2;
    hold          = 1'b0;
    flush         = 1'b0;
  endtask

  // Queue the expected outputs for the current cycle, then move past the next edge.
  task automatic step(input logic st, input logic [NREG-1:0] bz,
                      input logic [PERF_W-1:0] sc, input string nm);
    exp_q.push_back({st, bz, sc});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PERF_W-1:0] sat(input int v);
    return (v > 255) ? 8'd255 : PERF_W'(v);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      nm_s  = name_q.pop_front();
      act_w = {stall, busy, stall_count};
      total++;
      if (act_w !== exp_w) begin
        bad++;
        $display("FAIL %s: got stall=%0b busy=%02h count=%0d, want stall=%0b busy=%02h count=%0d",
                 nm_s, act_w[W-1], act_w[W-2 -: NREG], act_w[PERF_W-1:0],
                 exp_w[W-1], exp_w[W-2 -: NREG], exp_w[PERF_W-1:0]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    nop();
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 8'd0, "reset_state");
    rst = 1'b1;
    step(1'b0, 8'h00, 8'd0, "reset_release");

    // Asynchronous reset in the middle of two in-flight writes
    issue(3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd0, "pre_rst_w1");
    issue(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h02, 8'd0, "pre_rst_w2");
    nop(); rst = 1'b0;                               step(1'b0, 8'h00, 8'd0, "rst_async");
    rst = 1'b1;                                      step(1'b0, 8'h00, 8'd0, "rst_released");
    issue(3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd0, "post_rst_issue");
    nop();                                           step(1'b0, 8'h40, 8'd0, "post_rst_ex");
    step(1'b0, 8'h40, 8'd0, "post_rst_mem");
    step(1'b0, 8'h40, 8'd0, "post_rst_wb");
    step(1'b0, 8'h00, 8'd0, "post_rst_retired");

    // Load-use: exactly one stall cycle, then the reader is accepted
    issue(3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd0, "lu_load");
    issue(3'd1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0); step(1'b1, 8'h08, 8'd0, "lu_stall");
    step(1'b0, 8'h08, 8'd1, "lu_accept");
    nop();                                           step(1'b0, 8'h0a, 8'd1, "lu_drain1");
    step(1'b0, 8'h02, 8'd1, "lu_drain2");
    step(1'b0, 8'h02, 8'd1, "lu_drain3");
    step(1'b0, 8'h00, 8'd1, "lu_drain4");

    // No false stalls: ALU producer, unused source, load already in MEM
    issue(3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd1, "nf_alu_w3");
    issue(3'd1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0); step(1'b0, 8'h08, 8'd1, "nf_alu_reader");
    issue(3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h0a, 8'd1, "nf_load_r3");
    issue(3'd0, 1'b0, 1'b0, 3'd3, 1'b0, 3'd0, 1'b1); step(1'b0, 8'h0a, 8'd1, "nf_unused_src");
    nop();                                           step(1'b0, 8'h0a, 8'd1, "nf_drain1");
    step(1'b0, 8'h08, 8'd1, "nf_drain2");
    step(1'b0, 8'h00, 8'd1, "nf_drain3");
    issue(3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd1, "nf_load2");
    issue(3'd4, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0); step(1'b0, 8'h08, 8'd1, "nf_unrelated");
    issue(3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0); step(1'b0, 8'h18, 8'd1, "nf_mem_reader");
    nop();                                           step(1'b0, 8'h18, 8'd1, "nf_drain4");
    step(1'b0, 8'h10, 8'd1, "nf_drain5");
    step(1'b0, 8'h00, 8'd1, "nf_drain6");

    // Busy tracking: three writes to R5, then a fourth as the first retires
    issue(3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd1, "b5_w1");
    step(1'b0, 8'h20, 8'd1, "b5_w2");
    step(1'b0, 8'h20, 8'd1, "b5_w3");
    step(1'b0, 8'h20, 8'd1, "b5_w4_retire");
    nop();                                           step(1'b0, 8'h20, 8'd1, "b5_hold1");
    step(1'b0, 8'h20, 8'd1, "b5_hold2");
    step(1'b0, 8'h20, 8'd1, "b5_hold3");
    step(1'b0, 8'h00, 8'd1, "b5_clear");

    // Flush: load R2 in EX dropped, ALU R4 in MEM commits
    issue(3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd1, "fl_alu_r4");
    issue(3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h10, 8'd1, "fl_load_r2");
    issue(3'd1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0); flush = 1'b1;
    step(1'b1, 8'h14, 8'd1, "fl_flush");
    flush = 1'b0;                                    step(1'b0, 8'h10, 8'd1, "fl_no_stall");
    nop();                                           step(1'b0, 8'h02, 8'd1, "fl_r4_retired");
    step(1'b0, 8'h02, 8'd1, "fl_drain1");
    step(1'b0, 8'h02, 8'd1, "fl_drain2");
    step(1'b0, 8'h00, 8'd1, "fl_drain3");

    // Hold during a load-use: everything frozen while stall stays high
    issue(3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd1, "hd_load");
    issue(3'd1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0); hold = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h08, 8'd1, "hd_frozen");
    hold = 1'b0;                                     step(1'b1, 8'h08, 8'd1, "hd_release");
    step(1'b0, 8'h08, 8'd2, "hd_accept");
    nop();                                           step(1'b0, 8'h0a, 8'd2, "hd_drain1");
    step(1'b0, 8'h02, 8'd2, "hd_drain2");
    step(1'b0, 8'h02, 8'd2, "hd_drain3");
    step(1'b0, 8'h00, 8'd2, "hd_drain4");

    // Saturation: a load that reads its own target stalls on every other cycle
    issue(3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0); step(1'b0, 8'h00, 8'd2, "sat_seed");
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'h08, sat(2 + i), "sat_stall");
      step(1'b0, 8'h08, sat(3 + i), "sat_accept");
    end
    nop();                                           step(1'b0, 8'h08, 8'd255, "sat_final");
    step(1'b0, 8'h08, 8'd255, "sat_drain1");
    step(1'b0, 8'h08, 8'd255, "sat_drain2");
    step(1'b0, 8'h00, 8'd255, "sat_drain3");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Decode-stage hazard and in-flight-write tracker for the 5-stage core. It runs in the opposite direction to operand forwarding.
- It records each destination register as an instruction issues. It follows each write through EX, MEM and WB, and clears it when the write retires.
- It raises a load-use stall, which forwarding cannot cover, and exports a per-register busy map.
- Sits between the decode stage and the ID/EX register, and drives the PC/IF-ID hold and the EX bubble insertion.

Parameters:
- NREG, 8, number of architectural registers; register address width is 3.
- PERF_W, 8, width of the saturating load-use stall counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_Rdst  in  3  destination register of the decode instruction.
- issue_WB  in  1  decode instruction writes a register.
- issue_is_load  in  1  decode instruction is a memory load.
- Rsrc1  in  3  first source register.
- Rsrc2  in  3  second source register.
- use_src1  in  1  Rsrc1 is actually read.
- use_src2  in  1  Rsrc2 is actually read.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  branch/interrupt flush of the EX and MEM entries.
- stall  out  1  load-use stall; holds PC and IF/ID and bubbles EX. Combinational.
- busy  out  NREG  bit r = at least one in-flight write to register r. Registered.
- stall_count  out  PERF_W  saturating count of stall cycles.

Behaviour:
- Internal tag pipeline has three stages, EX, MEM and WB. Each tag holds {v, wb, rdst[2:0], ld}.
- Per-register pending counter is 2 bits wide, range 0..3.
- Reset (rst=0, asynchronous):
  - all tags cleared;
  - all counters 0;
  - busy=0, stall_count=0;
  - stall=0 while in reset.
- stall = EX.v & EX.wb & EX.ld & issue_valid & ((use_src1 & Rsrc1==EX.rdst) | (use_src2 & Rsrc2==EX.rdst)).
  - A match against MEM or WB never stalls; forwarding covers MEM, and the register file is write-before-read.
- accept = issue_valid & ~stall & ~hold & ~flush.
- Per clock edge, priority is reset > flush > hold > normal.
- Normal advance (hold=0, flush=0):
  - WB <= MEM, MEM <= EX.
  - EX <= accepted instruction, or a bubble (v=0) when not accepted.
- hold=1, flush=0: all tags and counters frozen. stall_count does not increment.
- flush=1:
  - EX and MEM are cleared.
  - WB <= old MEM; an instruction that already reached MEM commits.
  - Counters drop by the flushed EX entry only; MEM moved to WB and stays counted.
  - Decode is not accepted that cycle.
- Counter update, per register, evaluated in the same edge:
  - +1 on accept with issue_WB & issue_Rdst==r.
  - −1 when the WB tag leaves (v & wb & rdst==r, not held).
  - −1 for a flushed EX entry with rdst==r.
  - Net change is applied; simultaneous +1 and −1 leaves the count unchanged.
- Counter bounds:
  - The counter never exceeds 3 (three stages).
  - Overflow or underflow is an assertion failure, not wrapped.
- busy[r] <= (next counter[r] != 0).
- Latency: an instruction accepted at edge t sets busy at t. It occupies EX in cycle t..t+1, MEM next, then WB. Busy clears after the edge leaving WB, i.e. 3 edges after accept if no hold.
- stall_count increments on each edge where stall=1 & ~hold & ~flush, and saturates at all-ones.
- A stall lasts exactly one cycle per load-use pair: the bubble advances the load to MEM, and forwarding then takes over.
- Back-to-back loads are handled stage by stage; the stall depends only on EX.

Test Plan:
- Reset mid-run: after 2 issued writes, pulse rst low asynchronously → busy=0, stall=0, stall_count=0 immediately. The first accepted issue after release behaves normally.
- Load-use: issue LDD R3 (is_load), then ADD R1,R3 with use_src1 → stall=1 for exactly one cycle, EX gets a bubble, the ADD is accepted the next cycle, stall_count=1.
- No false stall:
  - ALU write R3 followed by a reader of R3 → stall=0.
  - Load R3 followed by a reader with use_src1=0 → stall=0.
  - Load R3, then an unrelated instruction, then a reader of R3 (load now in MEM) → stall=0.
- Busy tracking:
  - Three consecutive writes to R5 → counter reaches 3 and busy[5]=1.
  - busy[5] clears 3 edges after the last accept.
  - Simultaneous retire and issue on R5 keeps the count unchanged.
- Flush: with load R2 in EX and ALU R4 in MEM, assert flush → busy[2]=0 next cycle, busy[4] remains until R4 retires from WB, and no pending stall survives.
- Hold and saturation:
  - hold=1 for 5 cycles during a load-use → tags, busy and stall_count frozen while stall stays asserted.
  - Forcing 300 stall cycles saturates stall_count at 255.
